// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one C2 main-memory port between two line-granular
// masters. Round-robin arbitration, grant held for a whole line transaction,
// one dead TURN cycle afterwards, and a watchdog that frees the bus when
// memory stops responding.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; requests sampled, winner granted at the next edge
//   BUSY  | owner muxed onto the memory port until line end or watchdog
//   TURN  | one-cycle bus turnaround; everything NOP/0, requests ignored
module mem_bus_arbiter #(
  parameter int BUS_SIZE   = 16,
  parameter int ADDR_W     = 15,
  parameter int LINE_BEATS = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [1:0]          m0_cmd_in,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [BUS_SIZE-1:0] m0_wdata,
  output logic [1:0]          m0_cmd_out,
  output logic [BUS_SIZE-1:0] m0_rdata,

  input  logic [1:0]          m1_cmd_in,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [BUS_SIZE-1:0] m1_wdata,
  output logic [1:0]          m1_cmd_out,
  output logic [BUS_SIZE-1:0] m1_rdata,

  output logic [1:0]          s_cmd_out,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [BUS_SIZE-1:0] s_wdata,
  input  logic [1:0]          s_cmd_in,
  input  logic [BUS_SIZE-1:0] s_rdata,

  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_RESP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  // Counter widths leave headroom so LINE_BEATS-1 and TIMEOUT-1 always fit.
  localparam int CNT_W = $clog2(LINE_BEATS + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t           state;
  logic             last;      // 0: m0 owned the bus last, 1: m1
  logic [1:0]       op_reg;    // command latched at grant time
  logic [CNT_W-1:0] beat_cnt;  // read beats received so far
  logic [WD_W-1:0]  wdog;      // BUSY cycles since the last RESPONSE

  logic m0_req;
  logic m1_req;
  logic slave_resp;
  logic pick_m0;

  // Request decode and tie-break: m0 wins unless m1 is the only requester
  // or m0 held the bus last.
  always_comb begin
    m0_req     = (m0_cmd_in == CMD_READ) || (m0_cmd_in == CMD_WRITE);
    m1_req     = (m1_cmd_in == CMD_READ) || (m1_cmd_in == CMD_WRITE);
    slave_resp = (s_cmd_in == CMD_RESP);
    pick_m0    = m0_req && (!m1_req || last);
  end

  // Arbitration FSM with registered grant, owner history and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      op_reg      <= CMD_NOP;
      beat_cnt    <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            if (pick_m0) begin
              grant  <= 2'b01;
              last   <= 1'b0;
              op_reg <= m0_cmd_in;
            end else begin
              grant  <= 2'b10;
              last   <= 1'b1;
              op_reg <= m1_cmd_in;
            end
            beat_cnt <= '0;
            wdog     <= '0;
            state    <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (slave_resp) begin
            wdog <= '0;
            // A write completes on its single acknowledge; a read on the
            // last beat of the line.
            if ((op_reg == CMD_WRITE) || (beat_cnt == LAST_BEAT)) begin
              grant <= 2'b00;
              state <= ST_TURN;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end else if (wdog == WD_LIMIT) begin
            // TIMEOUT silent cycles in a row: memory is presumed dead.
            timeout_err <= 1'b1;
            grant       <= 2'b00;
            state       <= ST_TURN;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        ST_TURN: begin
          state <= ST_IDLE;
        end

        default: begin
          grant <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath mux: only the registered owner is connected, and only in BUSY.
  always_comb begin
    s_cmd_out  = CMD_NOP;
    s_addr     = '0;
    s_wdata    = '0;
    m0_cmd_out = CMD_NOP;
    m0_rdata   = '0;
    m1_cmd_out = CMD_NOP;
    m1_rdata   = '0;
    if (state == ST_BUSY) begin
      if (grant[1]) begin
        s_cmd_out  = m1_cmd_in;
        s_addr     = m1_addr;
        s_wdata    = m1_wdata;
        m1_cmd_out = slave_resp ? CMD_RESP : CMD_NOP;
        m1_rdata   = s_rdata;
      end else begin
        s_cmd_out  = m0_cmd_in;
        s_addr     = m0_addr;
        s_wdata    = m0_wdata;
        m0_cmd_out = slave_resp ? CMD_RESP : CMD_NOP;
        m0_rdata   = s_rdata;
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one main-memory port (C2 command protocol: NOP=0, RESPONSE=1, READ=2, WRITE=3) between two line-granular masters (cache instances, or cache plus refill engine).
- Round-robin arbitration.
- Grant is locked for a whole line transaction, followed by a 1-cycle bus turnaround.
- A watchdog releases the bus if memory never responds.

Parameters:
- BUS_SIZE, 16, width of the data bus in bits.
- ADDR_W, 15, line address width (memory address bits minus line offset bits).
- LINE_BEATS, 8, data beats per line (line bytes * 8 / BUS_SIZE).
- TIMEOUT, 255, cycles without a slave RESPONSE before forced release; must be > LINE_BEATS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- m0_cmd_in  in  2  master 0 command (READ/WRITE = request, held until done).
- m0_addr  in  ADDR_W  master 0 line address.
- m0_wdata  in  BUS_SIZE  master 0 write beat.
- m0_cmd_out  out  2  RESPONSE forwarded to master 0, else NOP.
- m0_rdata  out  BUS_SIZE  read beat to master 0, else 0.
- m1_*  same five ports for master 1.
- s_cmd_out  out  2  command to memory.
- s_addr  out  ADDR_W  address to memory.
- s_wdata  out  BUS_SIZE  write beat to memory.
- s_cmd_in  in  2  memory response (RESPONSE or NOP).
- s_rdata  in  BUS_SIZE  memory read beat.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 0 when no owner.
- timeout_err  out  1  1-cycle pulse on watchdog release.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, last=1 (so m0 wins the first tie), beat counter=0, watchdog=0, timeout_err=0.
  - s_cmd_out=NOP, s_addr=0, s_wdata=0, mN_cmd_out=NOP, mN_rdata=0.
- States: IDLE, BUSY, TURN.
- IDLE:
  - A master requests when its cmd_in is READ or WRITE.
  - At a posedge with exactly one requester, grant goes to it.
  - With two requesters, grant goes to the master != last.
  - On grant, latch owner's cmd into op_reg, set last=owner, clear counter and watchdog, move to BUSY.
  - Request-to-slave latency is 1 cycle: the slave sees the command in the cycle after the request is first sampled.
- BUSY (combinational muxing):
  - s_cmd_out/s_addr/s_wdata = owner's cmd_in/addr/wdata.
  - owner cmd_out = s_cmd_in; owner rdata = s_rdata.
  - Non-owner: cmd_out=NOP, rdata=0; its request stays pending.
- BUSY, read (op_reg=READ):
  - Each cycle with s_cmd_in=RESPONSE increments the beat counter.
  - The RESPONSE at count LINE_BEATS-1 ends the transaction -> TURN.
- BUSY, write (op_reg=WRITE):
  - Owner sequences its own beats on wdata; the arbiter passes them through.
  - The first RESPONSE ends the transaction -> TURN.
- Watchdog:
  - Counts BUSY cycles since the last RESPONSE; reset by each RESPONSE.
  - Reaching TIMEOUT -> pulse timeout_err for 1 cycle, go to TURN, owner gets no further RESPONSE.
- Owner drops cmd_in to NOP mid-transaction: no abort. Arbiter stays BUSY and forwards NOP until end condition or watchdog.
- TURN (exactly 1 cycle):
  - grant=0, all slave outputs NOP/0, all master outputs NOP/0.
  - Requests are not sampled; next state IDLE.
  - A back-to-back request from the other master is therefore granted at the IDLE edge, giving 2 dead cycles between transactions.
- Fairness: a master continuously requesting never waits more than one foreign transaction.
- s_cmd_in/s_rdata outside BUSY: ignored, never forwarded.
- grant and state are registered; the muxing is combinational from registered owner.

Test Plan:
- m0 READ addr 0x0123 alone; memory returns 8 RESPONSE beats 0x1000..0x1007 -> s_cmd_out=READ, s_addr=0x0123 one cycle after request; m0 receives all 8 beats; grant=01 then 00 in TURN; m1_cmd_out stays NOP.
- m0 and m1 both READ in the same cycle after reset -> m0 granted first; m1 granted at the edge following TURN; next simultaneous tie goes to m0 only if m1 was last.
- m1 WRITE addr 0x7FFF with beats 0xA5A5..; memory returns 1 RESPONSE after 8 cycles -> s_wdata mirrors m1_wdata each cycle; transaction ends on that RESPONSE; 1-cycle TURN follows.
- m0 READ, memory silent -> timeout_err pulses exactly at watchdog count TIMEOUT (255); grant clears; pending m1 granted next; late RESPONSE is not forwarded to m0.
- Reset asserted mid-read after 3 beats -> all outputs NOP/0 and grant=0 immediately (asynchronous); after release, m1-only request is granted in 1 cycle, and a tie goes to m0.
- Read with non-consecutive RESPONSE beats (gaps of 2 NOP cycles) -> counter ends only on the 8th RESPONSE; watchdog does not fire.
